cnt2_seq_decoder: RTL and testbench

//  Receive-side decoder for the 2-bit x-steered counter code (00->01/10, 01->10/hold, 10->11,
//  11->00/01). Watches the counter's count stream, recovers the x bit that caused each step,

---
 rtl/cnt2_seq_decoder.sv | 135 +++++++++++++
 tb/tb_cnt2_seq_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt2_seq_decoder.sv
// Receive-side decoder for the 2-bit x-steered counter code: recovers x bits,
// flags illegal steps, tracks lock and packs recovered bits into words.
module cnt2_seq_decoder #(
  parameter int WORD_W    = 8,
  parameter int RELOCK    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 code_valid,
  input  logic [1:0]           code_in,
  input  logic                 err_clr,
  output logic                 x_out,
  output logic                 x_valid,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 locked,
  output logic [WORD_W-1:0]    word_out,
  output logic                 word_valid
);

  // state | meaning
  // IDLE  | no reference code yet; first valid sample becomes prev
  // TRACK | locked; legal steps yield bits that are packed into words
  // LOST  | after an illegal step; counting consecutive legal steps to relock
  typedef enum logic [1:0] {IDLE, TRACK, LOST} state_t;

  localparam int BW = $clog2(WORD_W);
  localparam int RW = (RELOCK > 1) ? $clog2(RELOCK) : 1;
  localparam logic [BW-1:0] BIT_LAST    = BW'(WORD_W - 1);
  localparam logic [RW-1:0] RELOCK_LAST = RW'(RELOCK - 1);

  state_t            state;
  logic [1:0]        prev;
  logic [WORD_W-1:0] word;
  logic [BW-1:0]     bit_cnt;
  logic [RW-1:0]     relock_cnt;

  logic step_legal, step_has_bit, step_bit, err_now;

  always_comb begin
    step_legal   = 1'b1;
    step_has_bit = 1'b1;
    step_bit     = 1'b0;
    unique case ({prev, code_in})
      4'b00_01: step_bit = 1'b0;
      4'b00_10: step_bit = 1'b1;
      4'b01_10: step_bit = 1'b0;
      4'b01_01: step_bit = 1'b1;
      4'b11_00: step_bit = 1'b0;
      4'b11_01: step_bit = 1'b1;
      4'b10_11: step_has_bit = 1'b0;
      default: begin
        step_legal   = 1'b0;
        step_has_bit = 1'b0;
      end
    endcase
  end

  assign err_now = code_valid && (state != IDLE) && !step_legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prev       <= 2'b00;
      word       <= '0;
      bit_cnt    <= '0;
      relock_cnt <= '0;
      x_out      <= 1'b0;
      x_valid    <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      locked     <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      x_valid    <= 1'b0;
      err        <= 1'b0;
      word_valid <= 1'b0;

      // A clear coinciding with an error still counts that error.
      if (err_now)
        err_cnt <= err_clr ? ERR_CNT_W'(1) : ((&err_cnt) ? err_cnt : err_cnt + ERR_CNT_W'(1));
      else if (err_clr)
        err_cnt <= '0;

      if (code_valid) begin
        prev <= code_in;
        unique case (state)
          IDLE: begin
            state  <= TRACK;
            locked <= 1'b1;
          end
          TRACK: begin
            if (!step_legal) begin
              err        <= 1'b1;
              state      <= LOST;
              locked     <= 1'b0;
              relock_cnt <= '0;
              bit_cnt    <= '0;
              word       <= '0;
            end else if (step_has_bit) begin
              x_out   <= step_bit;
              x_valid <= 1'b1;
              word    <= {word[WORD_W-2:0], step_bit};
              if (bit_cnt == BIT_LAST) begin
                word_out   <= {word[WORD_W-2:0], step_bit};
                word_valid <= 1'b1;
                bit_cnt    <= '0;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
          LOST: begin
            if (!step_legal) begin
              err        <= 1'b1;
              relock_cnt <= '0;
            end else if (relock_cnt == RELOCK_LAST) begin
              state      <= TRACK;
              locked     <= 1'b1;
              relock_cnt <= '0;
              bit_cnt    <= '0;
              word       <= '0;
            end else begin
              relock_cnt <= relock_cnt + RW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnt2_seq_decoder.sv
// Bench for cnt2_seq_decoder: directed tables and sequences plus random
// stimulus, all checked against a step-table / queue based reference model.
module tb_cnt2_seq_decoder;

  logic       clk, reset, code_valid, err_clr;
  logic [1:0] code_in;
  logic       x_out, x_valid, err, locked, word_valid;
  logic [7:0] err_cnt, word_out;
  logic       x_out2, x_valid2, err2, locked2, word_valid2;
  logic [1:0] err_cnt2;
  logic [7:0] word_out2;

  cnt2_seq_decoder #(.WORD_W(8), .RELOCK(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code_in(code_in), .err_clr(err_clr),
    .x_out(x_out), .x_valid(x_valid), .err(err), .err_cnt(err_cnt), .locked(locked),
    .word_out(word_out), .word_valid(word_valid));

  // Narrow error counter variant shares the same stimulus.
  cnt2_seq_decoder #(.WORD_W(8), .RELOCK(4), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code_in(code_in), .err_clr(err_clr),
    .x_out(x_out2), .x_valid(x_valid2), .err(err2), .err_cnt(err_cnt2), .locked(locked2),
    .word_out(word_out2), .word_valid(word_valid2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Step table: -1 illegal, 2 legal without bit, else the recovered x.
  int step_x [16];

  int       m_state;   // 0 idle, 1 track, 2 lost
  int       m_prev, m_relock, m_errcnt, m_errcnt2;
  bit       m_bits[$];
  bit       m_xo, m_xv, m_err, m_wv;
  logic [7:0] m_wo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_relock = 0; m_errcnt = 0; m_errcnt2 = 0;
    m_bits.delete();
    m_xo = 0; m_xv = 0; m_err = 0; m_wv = 0; m_wo = 8'h00;
  endtask

  task automatic model_step(input bit v, input int c, input bit clr);
    int  s;
    bit  bad;
    m_xv = 0; m_err = 0; m_wv = 0;
    s   = step_x[m_prev*4 + c];
    bad = v && m_state != 0 && s == -1;
    if (bad) begin
      m_errcnt  = clr ? 1 : (m_errcnt  < 255 ? m_errcnt  + 1 : 255);
      m_errcnt2 = clr ? 1 : (m_errcnt2 < 3   ? m_errcnt2 + 1 : 3);
    end else if (clr) begin
      m_errcnt = 0; m_errcnt2 = 0;
    end
    if (v) begin
      if (m_state == 0) m_state = 1;
      else if (m_state == 1) begin
        if (bad) begin
          m_err = 1; m_state = 2; m_relock = 0; m_bits.delete();
        end else if (s != 2) begin
          m_xo = s[0]; m_xv = 1;
          m_bits.push_back(s[0]);
          if (m_bits.size() == 8) begin
            m_wo = 0;
            foreach (m_bits[i]) m_wo = m_wo * 2 + m_bits[i];
            m_wv = 1;
            m_bits.delete();
          end
        end
      end else begin
        if (bad) begin
          m_err = 1; m_relock = 0;
        end else begin
          m_relock++;
          if (m_relock == 4) begin
            m_state = 1; m_relock = 0; m_bits.delete();
          end
        end
      end
      m_prev = c;
    end
  endtask

  task automatic check_all();
    check("x_valid", x_valid, m_xv);
    check("x_out", x_out, m_xo);
    check("err", err, m_err);
    check("err_cnt", err_cnt, m_errcnt);
    check("err_cnt_w2", err_cnt2, m_errcnt2);
    check("locked", locked, m_state == 1);
    check("word_valid", word_valid, m_wv);
    check("word_out", word_out, m_wo);
  endtask

  task automatic cyc(input bit v, input logic [1:0] c, input bit clr);
    code_valid = v; code_in = c; err_clr = clr;
    @(posedge clk);
    model_step(v, int'(c), clr);
    #1;
    check_all();
  endtask

  typedef struct {
    logic [1:0] code;
    bit         xv;
    bit         xo;
    bit         wv;
    logic [7:0] wo;
  } vec_t;

  vec_t tbl [12];
  int   x_seen;

  initial begin
    foreach (step_x[i]) step_x[i] = -1;
    step_x[4'b0001] = 0; step_x[4'b0010] = 1; step_x[4'b0110] = 0;
    step_x[4'b0101] = 1; step_x[4'b1100] = 0; step_x[4'b1101] = 1;
    step_x[4'b1011] = 2;

    tbl[0]  = '{2'b00, 0, 0, 0, 8'h00};
    tbl[1]  = '{2'b01, 1, 0, 0, 8'h00};
    tbl[2]  = '{2'b10, 1, 0, 0, 8'h00};
    tbl[3]  = '{2'b11, 0, 0, 0, 8'h00};
    tbl[4]  = '{2'b00, 1, 0, 0, 8'h00};
    tbl[5]  = '{2'b10, 1, 1, 0, 8'h00};
    tbl[6]  = '{2'b11, 0, 0, 0, 8'h00};
    tbl[7]  = '{2'b01, 1, 1, 0, 8'h00};
    tbl[8]  = '{2'b01, 1, 1, 0, 8'h00};
    tbl[9]  = '{2'b10, 1, 0, 0, 8'h00};
    tbl[10] = '{2'b11, 0, 0, 0, 8'h00};
    tbl[11] = '{2'b00, 1, 0, 1, 8'h1C};

    // Reset held for two clocks
    reset = 1'b0; code_valid = 1'b0; code_in = 2'b00; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("reset_locked", locked, 0);
    reset = 1'b1;

    // First sample locks, then the reference stream yields word 1C
    foreach (tbl[i]) begin
      cyc(1'b1, tbl[i].code, 1'b0);
      check("tbl_locked", locked, 1);
      check("tbl_err", err, 0);
      check("tbl_x_valid", x_valid, tbl[i].xv);
      if (tbl[i].xv) check("tbl_x_out", x_out, tbl[i].xo);
      check("tbl_word_valid", word_valid, tbl[i].wv);
      if (tbl[i].wv) check("tbl_word_out", word_out, tbl[i].wo);
    end

    // Illegal step mid-word, relock after four legal steps, fresh word
    cyc(1, 2'b01, 0);
    cyc(1, 2'b10, 0);
    cyc(1, 2'b01, 0);
    check("illegal_err", err, 1);
    check("illegal_errcnt", err_cnt, 1);
    check("illegal_locked", locked, 0);
    cyc(1, 2'b10, 0); cyc(1, 2'b11, 0); cyc(1, 2'b00, 0);
    check("relock3_locked", locked, 0);
    cyc(1, 2'b01, 0);
    check("relock4_locked", locked, 1);
    check("relock4_x_valid", x_valid, 0);
    begin
      logic [1:0] seq [11] = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01,
                               2'b01, 2'b01, 2'b10, 2'b11, 2'b01};
      foreach (seq[i]) cyc(1, seq[i], 0);
    end
    check("fresh_word_valid", word_valid, 1);
    check("fresh_word", word_out, 8'h3D);

    // Idle gaps between samples change nothing
    x_seen = 0;
    cyc(1, 2'b10, 0);
    repeat (5) begin
      cyc(0, 2'($urandom_range(0, 3)), 0);
      x_seen += x_valid;
    end
    cyc(1, 2'b11, 0);
    repeat (5) cyc(0, 2'($urandom_range(0, 3)), 0);
    cyc(1, 2'b00, 0);
    cyc(1, 2'b01, 0);
    check("gap_x0", x_out, 0);
    repeat (2) begin
      repeat (5) begin
        cyc(0, 2'b11, 0);
        x_seen += x_valid;
      end
      cyc(1, 2'b01, 0);
      check("hold_x_valid", x_valid, 1);
      check("hold_x", x_out, 1);
    end
    check("gap_no_pulse", x_seen, 0);

    // Saturation of the 2-bit counter and clear with a coincident error
    cyc(0, 2'b00, 1);
    check("clr_alone", err_cnt2, 0);
    begin
      logic [1:0] exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      foreach (exp_sat[i]) begin
        cyc(1, 2'b00, 0);
        check("sat_err", err2, 1);
        check("sat_cnt", err_cnt2, exp_sat[i]);
      end
    end
    cyc(1, 2'b00, 1);
    check("clr_with_err", err_cnt2, 1);
    check("clr_with_err_w8", err_cnt, 1);

    // Reset mid-word discards partial bits
    cyc(1, 2'b01, 0); cyc(1, 2'b10, 0); cyc(1, 2'b11, 0); cyc(1, 2'b00, 0);
    check("relock_b_locked", locked, 1);
    begin
      logic [1:0] seq [7] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01};
      foreach (seq[i]) cyc(1, seq[i], 0);
    end
    reset = 1'b0;
    code_valid = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cyc(1, 2'b00, 0);
    begin
      logic [1:0] seq [10] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00,
                               2'b10, 2'b11, 2'b01, 2'b10};
      foreach (seq[i]) cyc(1, seq[i], 0);
    end
    check("post_reset_word_valid", word_valid, 1);
    check("post_reset_word", word_out, 8'h66);

    // Random traffic, mostly legal steps
    for (int n = 0; n < 3000; n++) begin
      int          cand[$];
      logic [1:0]  c;
      cand.delete();
      for (int k = 0; k < 4; k++) if (step_x[m_prev*4 + k] != -1) cand.push_back(k);
      if ($urandom_range(0, 99) < 85 && cand.size() > 0)
        c = 2'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        c = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 99) < 75, c, $urandom_range(0, 99) < 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
